// File: rtl/debug_unit_controller_if.sv
// Byte-wide UART stream between the debug unit controller (master) and the UART (slave).
// rx_done / tx_start / tx_done are single-cycle strobes: rx_data is valid only while rx_done is high,
// tx_start launches tx_data, and tx_data must stay put until tx_done reports the transmitter is idle.
interface debug_unit_controller_if #(
   parameter int NB_MEM_WIDTH = 8
);
   logic [NB_MEM_WIDTH-1:0] rx_data;
   logic                    rx_done;
   logic [NB_MEM_WIDTH-1:0] tx_data;
   logic                    tx_start;
   logic                    tx_done;

   modport master (input rx_data, rx_done, tx_done, output tx_data, tx_start);
   modport slave  (output rx_data, rx_done, tx_done, input tx_data, tx_start);
endinterface

// File: rtl/debug_unit_controller.sv
// Host-side debug controller: loads the program from UART, runs/steps the pipeline,
// then streams back last PC, the register bank and data memory over UART.
module debug_unit_controller #(
   parameter int NB_PC               = 32,
   parameter int NB_DATA             = 32,
   parameter int NB_REG              = 5,
   parameter int NB_ADDR             = 32,
   parameter int NB_memory_data_ADDR = 7,
   parameter int NB_MEM_WIDTH        = 8
) (
   input  logic                           i_clock,
   input  logic                           i_reset,
   debug_unit_controller_if.master        uart,
   input  logic                           i_halt,
   input  logic [NB_PC-1:0]               i_last_pc,
   input  logic [NB_DATA-1:0]             i_bank_register_data,
   input  logic [NB_MEM_WIDTH-1:0]        i_mem_data_data,
   output logic                           o_pc_enable,
   output logic                           o_read_enable,
   output logic                           o_pipeline_enable,
   output logic                           o_pc_reset,
   output logic                           o_ID_reset,
   output logic                           o_reset_forward_stall,
   output logic                           o_instru_mem_enable,
   output logic                           o_bank_register_enable,
   output logic                           o_mem_data_enable,
   output logic                           o_unit_control_enable,
   output logic                           o_instru_mem_write_enable,
   output logic [NB_MEM_WIDTH-1:0]        o_instru_mem_data,
   output logic [NB_ADDR-1:0]             o_instru_mem_addr,
   output logic                           o_bank_register_read_enable,
   output logic [NB_REG-1:0]              o_bank_register_addr,
   output logic                           o_mem_data_read_enable,
   output logic [NB_memory_data_ADDR-1:0] o_mem_data_read_addr,
   output logic                           o_MEM_debug_unit_flag,
   output logic [3:0]                     o_debug_state
);

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      LOAD_LEN  = 4'd1,
      LOAD_BYTE = 4'd2,
      RUN       = 4'd3,
      STEP      = 4'd4,
      DUMP_PC   = 4'd5,
      DUMP_REG  = 4'd6,
      DUMP_MEM  = 4'd7,
      TX_WAIT   = 4'd8
   } state_e;

   localparam logic [NB_MEM_WIDTH-1:0] CMD_LOAD = 8'h01;
   localparam logic [NB_MEM_WIDTH-1:0] CMD_RUN  = 8'h02;
   localparam logic [NB_MEM_WIDTH-1:0] CMD_STEP = 8'h03;

   state_e                          state;
   state_e                          ret_state;
   logic                            halted;
   logic                            loaded;
   logic                            adv_en;
   logic                            pipe_rst;
   logic                            unit_en;
   logic                            wr_en;
   logic [NB_MEM_WIDTH-1:0]         wr_data;
   logic [NB_ADDR-1:0]              wr_addr;
   logic [NB_ADDR-1:0]              byte_addr;
   logic [10:0]                     load_total;
   logic                            reg_rd;
   logic [NB_REG-1:0]               reg_idx;
   logic                            mem_rd;
   logic [NB_memory_data_ADDR-1:0]  mem_addr;
   logic                            mem_flag;
   logic [NB_DATA-1:0]              dump_word;
   logic [1:0]                      byte_idx;
   logic [1:0]                      rd_phase;
   logic [NB_MEM_WIDTH-1:0]         tx_data;
   logic                            tx_start;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state      <= IDLE;
         ret_state  <= IDLE;
         halted     <= 1'b0;
         loaded     <= 1'b0;
         adv_en     <= 1'b0;
         pipe_rst   <= 1'b1;
         unit_en    <= 1'b0;
         wr_en      <= 1'b0;
         wr_data    <= '0;
         wr_addr    <= '0;
         byte_addr  <= '0;
         load_total <= '0;
         reg_rd     <= 1'b0;
         reg_idx    <= '0;
         mem_rd     <= 1'b0;
         mem_addr   <= '0;
         mem_flag   <= 1'b0;
         dump_word  <= '0;
         byte_idx   <= '0;
         rd_phase   <= '0;
         tx_data    <= '0;
         tx_start   <= 1'b0;
      end else begin
         unit_en  <= 1'b1;
         wr_en    <= 1'b0;
         tx_start <= 1'b0;
         reg_rd   <= 1'b0;
         mem_rd   <= 1'b0;
         adv_en   <= 1'b0;

         case (state)
            IDLE: begin
               if (loaded) pipe_rst <= 1'b0;
               if (uart.rx_done) begin
                  case (uart.rx_data)
                     CMD_LOAD: begin
                        state    <= LOAD_LEN;
                        pipe_rst <= 1'b1;
                     end
                     CMD_RUN: begin
                        if (halted) state <= DUMP_PC;
                        else begin
                           state  <= RUN;
                           adv_en <= 1'b1;
                        end
                     end
                     CMD_STEP: begin
                        if (halted) state <= DUMP_PC;
                        else begin
                           state  <= STEP;
                           adv_en <= 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
            end

            LOAD_LEN: begin
               if (uart.rx_done) begin
                  // A word count of zero stands for 256 words.
                  load_total <= (uart.rx_data == '0) ? 11'd1024 : {1'b0, uart.rx_data, 2'b00};
                  byte_addr  <= '0;
                  halted     <= 1'b0;
                  state      <= LOAD_BYTE;
               end
            end

            LOAD_BYTE: begin
               if (uart.rx_done) begin
                  wr_data   <= uart.rx_data;
                  wr_addr   <= byte_addr;
                  wr_en     <= 1'b1;
                  byte_addr <= byte_addr + 1'b1;
                  if (byte_addr[10:0] + 11'd1 == load_total) begin
                     state  <= IDLE;
                     loaded <= 1'b1;
                  end
               end
            end

            RUN: begin
               if (i_halt) begin
                  halted <= 1'b1;
                  state  <= DUMP_PC;
               end else begin
                  adv_en <= 1'b1;
               end
            end

            STEP: begin
               if (i_halt) halted <= 1'b1;
               state <= DUMP_PC;
            end

            DUMP_PC: begin
               if (rd_phase == 2'd0) begin
                  dump_word <= NB_DATA'(i_last_pc);
                  rd_phase  <= 2'd3;
               end else begin
                  tx_data   <= dump_word[NB_DATA-1 -: NB_MEM_WIDTH];
                  dump_word <= dump_word << NB_MEM_WIDTH;
                  tx_start  <= 1'b1;
                  byte_idx  <= byte_idx + 1'b1;
                  state     <= TX_WAIT;
                  if (byte_idx == 2'd3) begin
                     ret_state <= DUMP_REG;
                     reg_idx   <= '0;
                     rd_phase  <= 2'd0;
                  end else begin
                     ret_state <= DUMP_PC;
                  end
               end
            end

            // Register reads: request, wait one cycle of read latency, capture, then send 4 bytes.
            DUMP_REG: begin
               case (rd_phase)
                  2'd0: begin
                     reg_rd   <= 1'b1;
                     rd_phase <= 2'd1;
                  end
                  2'd1: rd_phase <= 2'd2;
                  2'd2: begin
                     dump_word <= i_bank_register_data;
                     rd_phase  <= 2'd3;
                  end
                  default: begin
                     tx_data   <= dump_word[NB_DATA-1 -: NB_MEM_WIDTH];
                     dump_word <= dump_word << NB_MEM_WIDTH;
                     tx_start  <= 1'b1;
                     byte_idx  <= byte_idx + 1'b1;
                     state     <= TX_WAIT;
                     ret_state <= DUMP_REG;
                     if (byte_idx == 2'd3) begin
                        rd_phase <= 2'd0;
                        if (&reg_idx) begin
                           ret_state <= DUMP_MEM;
                           mem_addr  <= '0;
                        end else begin
                           reg_idx <= reg_idx + 1'b1;
                        end
                     end
                  end
               endcase
            end

            DUMP_MEM: begin
               case (rd_phase)
                  2'd0: begin
                     mem_rd   <= 1'b1;
                     rd_phase <= 2'd1;
                  end
                  2'd1: rd_phase <= 2'd2;
                  default: begin
                     tx_data  <= i_mem_data_data;
                     tx_start <= 1'b1;
                     state    <= TX_WAIT;
                     rd_phase <= 2'd0;
                     if (&mem_addr) begin
                        ret_state <= IDLE;
                     end else begin
                        mem_addr  <= mem_addr + 1'b1;
                        ret_state <= DUMP_MEM;
                     end
                  end
               endcase
            end

            TX_WAIT: begin
               if (uart.tx_done) begin
                  state    <= ret_state;
                  mem_flag <= (ret_state == DUMP_MEM);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign uart.tx_data                = tx_data;
   assign uart.tx_start               = tx_start;
   assign o_pc_enable                 = adv_en;
   assign o_read_enable               = adv_en;
   assign o_pipeline_enable           = adv_en;
   assign o_pc_reset                  = pipe_rst;
   assign o_ID_reset                  = pipe_rst;
   assign o_reset_forward_stall       = pipe_rst;
   assign o_instru_mem_enable         = unit_en;
   assign o_bank_register_enable      = unit_en;
   assign o_mem_data_enable           = unit_en;
   assign o_unit_control_enable       = unit_en;
   assign o_instru_mem_write_enable   = wr_en;
   assign o_instru_mem_data           = wr_data;
   assign o_instru_mem_addr           = wr_addr;
   assign o_bank_register_read_enable = reg_rd;
   assign o_bank_register_addr        = reg_idx;
   assign o_mem_data_read_enable      = mem_rd;
   assign o_mem_data_read_addr        = mem_addr;
   assign o_MEM_debug_unit_flag       = mem_flag;
   assign o_debug_state               = state;

endmodule

// File: tb/tb_debug_unit_controller.sv
// Directed bench for debug_unit_controller: load, run, step, dump and mid-dump reset,
// with pipeline/memory models and a UART transmitter responder.
module tb_debug_unit_controller;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   debug_unit_controller_if uart ();

   logic        i_halt;
   logic [31:0] last_pc;
   logic [31:0] reg_rdata;
   logic [7:0]  mem_rdata;
   logic        o_pc_enable, o_read_enable, o_pipeline_enable;
   logic        o_pc_reset, o_ID_reset, o_reset_forward_stall;
   logic        o_instru_mem_enable, o_bank_register_enable, o_mem_data_enable, o_unit_control_enable;
   logic        o_instru_mem_write_enable;
   logic [7:0]  o_instru_mem_data;
   logic [31:0] o_instru_mem_addr;
   logic        o_bank_register_read_enable;
   logic [4:0]  o_bank_register_addr;
   logic        o_mem_data_read_enable;
   logic [6:0]  o_mem_data_read_addr;
   logic        o_MEM_debug_unit_flag;
   logic [3:0]  o_debug_state;

   debug_unit_controller dut (
      .i_clock                     (clk),
      .i_reset                     (rst),
      .uart                        (uart.master),
      .i_halt                      (i_halt),
      .i_last_pc                   (last_pc),
      .i_bank_register_data        (reg_rdata),
      .i_mem_data_data             (mem_rdata),
      .o_pc_enable                 (o_pc_enable),
      .o_read_enable               (o_read_enable),
      .o_pipeline_enable           (o_pipeline_enable),
      .o_pc_reset                  (o_pc_reset),
      .o_ID_reset                  (o_ID_reset),
      .o_reset_forward_stall       (o_reset_forward_stall),
      .o_instru_mem_enable         (o_instru_mem_enable),
      .o_bank_register_enable      (o_bank_register_enable),
      .o_mem_data_enable           (o_mem_data_enable),
      .o_unit_control_enable       (o_unit_control_enable),
      .o_instru_mem_write_enable   (o_instru_mem_write_enable),
      .o_instru_mem_data           (o_instru_mem_data),
      .o_instru_mem_addr           (o_instru_mem_addr),
      .o_bank_register_read_enable (o_bank_register_read_enable),
      .o_bank_register_addr        (o_bank_register_addr),
      .o_mem_data_read_enable      (o_mem_data_read_enable),
      .o_mem_data_read_addr        (o_mem_data_read_addr),
      .o_MEM_debug_unit_flag       (o_MEM_debug_unit_flag),
      .o_debug_state               (o_debug_state)
   );

   // ---------------- scoreboard state ----------------
   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];
   logic [15:0] wr_q[$];
   int n_tests = 0;
   int n_fail  = 0;
   int en_count = 0;
   int halt_after = 0;
   int tx_delay = 1;
   int hold_viol = 0;
   int wr_reset_viol = 0;
   int en_mismatch = 0;
   int flag_viol = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- pipeline and memory models ----------------
   always @(posedge clk) begin
      if (o_bank_register_read_enable) reg_rdata <= 32'hA000_0000 + 32'(o_bank_register_addr);
      if (o_mem_data_read_enable)      mem_rdata <= 8'(o_mem_data_read_addr);
   end

   always @(negedge clk) begin
      if (o_pc_enable) begin
         en_count++;
         if (en_count == halt_after) i_halt = 1'b1;
      end
      if (o_pc_enable !== o_read_enable || o_pc_enable !== o_pipeline_enable ||
          o_pc_reset !== o_ID_reset || o_pc_reset !== o_reset_forward_stall ||
          o_instru_mem_enable !== o_bank_register_enable ||
          o_instru_mem_enable !== o_mem_data_enable ||
          o_instru_mem_enable !== o_unit_control_enable)
         en_mismatch++;
      if (o_instru_mem_write_enable) begin
         wr_q.push_back({o_instru_mem_addr[7:0], o_instru_mem_data});
         if (o_pc_reset !== 1'b1) wr_reset_viol++;
      end
      if (o_mem_data_read_enable && !o_MEM_debug_unit_flag) flag_viol++;
   end

   // UART transmitter: record each strobed byte, hold busy for tx_delay cycles, pulse done.
   always begin
      @(negedge clk);
      if (uart.tx_start === 1'b1) begin
         logic [7:0] held;
         bit aborted;
         aborted = 1'b0;
         held = uart.tx_data;
         got_q.push_back(uart.tx_data);
         repeat (tx_delay) begin
            @(negedge clk);
            if (rst) aborted = 1'b1;
            if (!aborted && (uart.tx_start !== 1'b0 || uart.tx_data !== held)) hold_viol++;
         end
         uart.tx_done = 1'b1;
         @(negedge clk);
         uart.tx_done = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_rx(input logic [7:0] b);
      @(negedge clk);
      uart.rx_data = b;
      uart.rx_done = 1'b1;
      @(negedge clk);
      uart.rx_done = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic build_exp();
      exp_q.delete();
      for (int i = 0; i < 4; i++) begin
         logic [31:0] pc;
         pc = last_pc;
         exp_q.push_back(pc[31-8*i -: 8]);
      end
      for (int r = 0; r < 32; r++) begin
         exp_q.push_back(8'hA0);
         exp_q.push_back(8'h00);
         exp_q.push_back(8'h00);
         exp_q.push_back(8'(r));
      end
      for (int m = 0; m < 128; m++) exp_q.push_back(8'(m));
   endtask

   task automatic wait_bytes(input string tag, input int count);
      int n;
      n = 0;
      while (got_q.size() < count && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(n < 20000), 32'd1);
   endtask

   task automatic wait_dump(input string tag);
      int n;
      n = 0;
      while (!(got_q.size() == 260 && o_debug_state == 4'd0) && n < 40000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_timeout"}, 32'(n < 40000), 32'd1);
   endtask

   task automatic compare_dump(input string tag);
      int bad;
      bad = 0;
      check({tag, "_len"}, got_q.size(), 32'd260);
      for (int i = 0; i < 260 && i < got_q.size(); i++)
         if (got_q[i] !== exp_q[i]) bad++;
      check({tag, "_bytes"}, bad, 32'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst          = 1'b1;
      i_halt       = 1'b0;
      last_pc      = 32'h0000_0008;
      reg_rdata    = '0;
      mem_rdata    = '0;
      uart.rx_data = '0;
      uart.rx_done = 1'b0;
      uart.tx_done = 1'b0;
      build_exp();

      repeat (2) @(negedge clk);
      check("rst_state",     32'(o_debug_state), 32'd0);
      check("rst_pipe_rst",  32'(o_pc_reset), 32'd1);
      check("rst_adv_en",    32'(o_pc_enable), 32'd0);
      check("rst_unit_en",   32'(o_instru_mem_enable), 32'd0);
      check("rst_tx_start",  32'(uart.tx_start), 32'd0);
      check("rst_tx_data",   32'(uart.tx_data), 32'd0);
      check("rst_wr_en",     32'(o_instru_mem_write_enable), 32'd0);
      check("rst_mem_flag",  32'(o_MEM_debug_unit_flag), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("unit_en_after_rst", 32'(o_instru_mem_enable), 32'd1);
      check("pipe_rst_unloaded", 32'(o_pc_reset), 32'd1);

      // Load 2 words
      wr_q.delete();
      send_rx(8'h01);
      send_rx(8'h02);
      for (int i = 0; i < 8; i++) send_rx(8'h11 + 8'(i));
      check("load_wr_count", wr_q.size(), 32'd8);
      for (int i = 0; i < 8 && i < wr_q.size(); i++)
         check("load_wr_addr_data", 32'(wr_q[i]), 32'({8'(i), 8'h11 + 8'(i)}));
      check("load_rst_during", wr_reset_viol, 32'd0);
      check("load_rst_after", 32'(o_pc_reset), 32'd0);
      check("load_state_idle", 32'(o_debug_state), 32'd0);

      send_rx(8'h55);
      check("unknown_cmd_idle", 32'(o_debug_state), 32'd0);

      // Run until the pipeline model halts after 5 enable cycles
      got_q.delete();
      en_count   = 0;
      halt_after = 5;
      send_rx(8'h02);
      wait_bytes("run_partial", 20);
      send_rx(8'h01);
      send_rx(8'h55);
      wait_dump("run");
      check("run_enable_cycles", en_count, 32'd5);
      for (int i = 0; i < 4 && i < got_q.size(); i++)
         check("run_pc_byte", 32'(got_q[i]), (i == 3) ? 32'h08 : 32'h00);
      compare_dump("run_dump");
      check("run_mem_flag_end", 32'(o_MEM_debug_unit_flag), 32'd0);

      // Run again while halted, with a slow first transmit
      got_q.delete();
      en_count  = 0;
      hold_viol = 0;
      tx_delay  = 100;
      send_rx(8'h02);
      wait_bytes("halted_first_byte", 1);
      tx_delay = 1;
      wait_dump("halted_run");
      check("halted_enable_cycles", en_count, 32'd0);
      if (got_q.size() == 260) check("halted_last_byte", 32'(got_q[259]), 32'h7F);
      else check("halted_last_byte_len", got_q.size(), 32'd260);
      compare_dump("halted_dump");
      check("tx_hold", hold_viol, 32'd0);

      // Reload 1 word, then single step
      i_halt     = 1'b0;
      halt_after = 0;
      send_rx(8'h01);
      send_rx(8'h01);
      for (int i = 0; i < 4; i++) send_rx(8'hA0 + 8'(i));
      check("reload_rst_after", 32'(o_pc_reset), 32'd0);
      got_q.delete();
      en_count = 0;
      send_rx(8'h03);
      wait_dump("step");
      check("step_enable_cycles", en_count, 32'd1);
      if (got_q.size() == 260) begin
         check("step_reg0_b0", 32'(got_q[4]),   32'hA0);
         check("step_reg0_b3", 32'(got_q[7]),   32'h00);
         check("step_reg31_b0", 32'(got_q[128]), 32'hA0);
         check("step_reg31_b3", 32'(got_q[131]), 32'h1F);
      end else check("step_len", got_q.size(), 32'd260);
      compare_dump("step_dump");
      check("enable_groups", en_mismatch, 32'd0);
      check("mem_flag_read", flag_viol, 32'd0);

      // Reset in the middle of a dump
      got_q.delete();
      send_rx(8'h03);
      wait_bytes("middump_10", 10);
      rst = 1'b1;
      @(negedge clk);
      check("middump_state", 32'(o_debug_state), 32'd0);
      check("middump_tx_start", 32'(uart.tx_start), 32'd0);
      check("middump_tx_data", 32'(uart.tx_data), 32'd0);
      check("middump_pipe_rst", 32'(o_pc_reset), 32'd1);
      check("middump_reg_rd", 32'(o_bank_register_read_enable), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      check("middump_no_more_tx", got_q.size(), 32'd10);
      check("middump_idle", 32'(o_debug_state), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
